// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_e;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshakes plus FIFO write port, seen from the arbiter (master) and its surroundings (slave).
interface fifo_wr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    localparam int IDX_W = fifo_arb_pkg::clog2_min1(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   full;
    logic [WIDTH-1:0]       write_data;
    logic                   write_enable;
    logic [IDX_W-1:0]       grant_id;
    logic                   busy;

    modport master (
        input  req_valid, req_data, full,
        output req_ready, write_data, write_enable, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, full,
        input  req_ready, write_data, write_enable, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// Combinational rotate-priority encoder: first masked request after `last`, wrapping, `last` lowest.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [N_REQ-1:0] req_m;
    logic [IDX_W-1:0] cand;

    assign req_m = req & mask;

    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((int'(last) + off) % N_REQ);
            if (!any && req_m[cand]) begin
                any  = 1'b1;
                pick = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, bursts of up to MAX_BURST beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 2
) (
    input logic             clk,
    input logic             rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int IDX_W = clog2_min1(N_REQ);
    localparam int CNT_W = clog2_min1(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] beat_cnt;

    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] pick_mask;
    logic [IDX_W-1:0] pick;
    logic             any;
    logic             owner_valid;
    logic             xfer;
    logic             release_burst;
    logic [WIDTH-1:0] owner_data;

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
    end

    assign owner_valid   = bus.req_valid[owner];
    assign xfer          = (state == ARB_BURST) && owner_valid && !bus.full;
    assign release_burst = (xfer && (beat_cnt == BEAT_LAST)) || !owner_valid;

    // A releasing owner that has gone idle must not win its own handoff.
    assign pick_mask = ((state == ARB_BURST) && !owner_valid) ? ~owner_oh : '1;

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (bus.req_valid),
        .mask (pick_mask),
        .last (last),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        owner_data = bus.req_data[WIDTH-1:0];
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == IDX_W'(i)) owner_data = bus.req_data[i*WIDTH +: WIDTH];
        end
    end

    // Handshake stays combinational so the FIFO and the producer see the same beat at the same edge.
    assign bus.req_ready    = xfer ? owner_oh : '0;
    assign bus.write_enable = xfer;
    assign bus.write_data   = owner_data;
    assign bus.grant_id     = owner;
    assign bus.busy         = (state == ARB_BURST);

    // NOTE: state registers use non-blocking assignments so every update in this block sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            last     <= LAST_RST;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        state    <= ARB_BURST;
                        owner    <= pick;
                        last     <= pick;
                        beat_cnt <= '0;
                    end
                end
                ARB_BURST: begin
                    if (release_burst) begin
                        if (any) begin
                            owner    <= pick;
                            last     <= pick;
                            beat_cnt <= '0;
                        end else begin
                            state <= ARB_IDLE;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed producer scenarios, monitor checks every FIFO write.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int MB = 2;

    typedef struct {
        int id;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    int     cycle    = 0;
    exp_t   exp_q[$];
    int     wr_cyc[$];
    int     cnt[N];
    int     kidx[N];
    logic [N-1:0] fired = '0;
    exp_t   mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_wr(input int id, input int data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Producer i, beat k presents i*4 + (k mod 4).
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]        = (cnt[i] > 0);
            bus.req_data[i*W +: W]  = W'(i * 4 + kidx[i] % 4);
        end
    endtask

    task automatic set_prod(input int i, input int words);
        cnt[i]  = words;
        kidx[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fired[i]) begin
                cnt[i]--;
                kidx[i]++;
            end
        end
        drive();
    endtask

    task automatic drain(input string name, input int limit);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            tick();
            t++;
        end
        repeat (3) tick();
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    function automatic int span();
        return (wr_cyc.size() == 0) ? -1 : wr_cyc[wr_cyc.size()-1] - wr_cyc[0];
    endfunction

    always @(posedge clk) cycle++;

    // Monitor: records accepted handshakes and checks each FIFO write against the scoreboard.
    always @(negedge clk) begin
        fired = bus.req_valid & bus.req_ready;
        if (bus.write_enable === 1'b1) begin
            wr_cyc.push_back(cycle);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got data %0h from grant %0d, expected no write (t=%0t)",
                         bus.write_data, bus.grant_id, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_data",  bus.write_data, mon_e.data);
                check("wr_grant", bus.grant_id,   mon_e.id);
                check("wr_ready", bus.req_ready,  1 << mon_e.id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.full = 1'b0;
        for (int i = 0; i < N; i++) set_prod(i, 0);
        drive();

        // Reset with all producers valid, then an all-valid round-robin sweep.
        set_prod(0, 3);
        set_prod(1, 2);
        set_prod(2, 2);
        set_prod(3, 2);
        drive();
        expect_wr(0, 0);  expect_wr(0, 1);
        expect_wr(1, 4);  expect_wr(1, 5);
        expect_wr(2, 8);  expect_wr(2, 9);
        expect_wr(3, 12); expect_wr(3, 13);
        expect_wr(0, 2);
        repeat (2) @(negedge clk);
        check("rst_we",    bus.write_enable, 0);
        check("rst_ready", bus.req_ready,    0);
        check("rst_grant", bus.grant_id,     0);
        check("rst_busy",  bus.busy,         0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_latency_we", bus.write_enable, 0);
        tick();
        @(negedge clk);
        check("first_grant", bus.grant_id, 0);
        check("first_busy",  bus.busy,     1);
        drain("sweep", 40);
        check("sweep_writes", wr_cyc.size(), 9);
        check("sweep_span",   span(),        8);

        // Single producer: back-to-back re-grants with no bubble.
        wr_cyc.delete();
        set_prod(2, 5);
        drive();
        expect_wr(2, 8); expect_wr(2, 9); expect_wr(2, 10); expect_wr(2, 11); expect_wr(2, 8);
        drain("solo", 40);
        check("solo_writes", wr_cyc.size(), 5);
        check("solo_span",   span(),        4);

        // FIFO full for three cycles in the middle of producer 1's burst.
        wr_cyc.delete();
        set_prod(1, 2);
        set_prod(2, 2);
        drive();
        expect_wr(1, 4); expect_wr(1, 5); expect_wr(2, 8); expect_wr(2, 9);
        tick();
        tick();
        bus.full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("full_we",    bus.write_enable, 0);
            check("full_ready", bus.req_ready,    0);
            check("full_owner", bus.grant_id,     1);
            tick();
        end
        bus.full = 1'b0;
        drain("full", 40);
        check("full_writes", wr_cyc.size(), 4);
        check("full_span",   span(),        6);

        // Owner 0 drops after one beat; waiting producer 3 takes over after a single empty cycle.
        wr_cyc.delete();
        set_prod(0, 1);
        drive();
        expect_wr(0, 0); expect_wr(3, 12); expect_wr(3, 13);
        tick();
        set_prod(3, 2);
        drive();
        tick();
        @(negedge clk);
        check("drop_cycle_we", bus.write_enable, 0);
        tick();
        @(negedge clk);
        check("drop_handoff_grant", bus.grant_id, 3);
        drain("drop", 40);
        check("drop_writes", wr_cyc.size(), 3);
        if (wr_cyc.size() >= 2) check("drop_gap", wr_cyc[1] - wr_cyc[0], 2);

        // Reset pulsed mid-burst of producer 2; arbitration restarts at producer 0.
        wr_cyc.delete();
        set_prod(2, 4);
        drive();
        expect_wr(2, 8);
        tick();
        tick();
        set_prod(0, 1);
        set_prod(1, 1);
        set_prod(3, 1);
        drive();
        expect_wr(0, 0);  expect_wr(1, 4);
        expect_wr(2, 9);  expect_wr(2, 10);
        expect_wr(3, 12); expect_wr(2, 11);
        check("pre_rst_we", bus.write_enable, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_we",    bus.write_enable, 0);
        check("rst_mid_ready", bus.req_ready,    0);
        check("rst_mid_busy",  bus.busy,         0);
        check("rst_mid_grant", bus.grant_id,     0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_we", bus.write_enable, 0);
        tick();
        @(negedge clk);
        check("post_rst_grant", bus.grant_id, 0);
        check("post_rst_busy",  bus.busy,     1);
        drain("rst_mid", 60);
        check("rst_mid_writes", wr_cyc.size(), 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
